// File: rtl/hex_codec_pkg.sv
// Shared constants, state type and one-hot helper for the hex encode/decode blocks.
package hex_codec_pkg;

    localparam int unsigned IN_W  = 4;
    localparam int unsigned OUT_W = 16;

    typedef enum logic {
        S_PASS,
        S_SWEEP
    } dec_state_t;

    // One-hot word with bit[code] set.
    function automatic logic [OUT_W-1:0] onehot_of(input logic [IN_W-1:0] code);
        logic [OUT_W-1:0] word;
        word       = '0;
        word[code] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/hs_reg_slice.sv
// Single-entry valid/ready register slice. Data holds its last value once drained.
module hs_reg_slice #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Slot is free when empty or being drained this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Load on accept; otherwise drop valid when the word is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/hex_onehot_decoder_seq.sv
// Registered 4-bit code to 16-bit one-hot decoder with valid/ready on both sides
// and a built-in 0..15 sweep generator for self-test.
module hex_onehot_decoder_seq
    import hex_codec_pkg::*;
#(
    parameter int unsigned SWEEP_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [IN_W-1:0]  out_code,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done
);

    localparam bit              SweepOn  = (SWEEP_EN != 0);
    localparam logic [IN_W-1:0] LastCode = IN_W'(OUT_W - 1);

    dec_state_t      state_q, state_d;
    logic [IN_W-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    logic             slot_free;
    logic             load;
    logic [IN_W-1:0]  load_code;
    logic [OUT_W-1:0] load_onehot;
    logic [IN_W-1:0]  cnt_nxt;

    assign cnt_nxt = cnt_q + 1'b1;

    // Next state, sweep counter and what (if anything) goes into the output slice.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        load        = 1'b0;
        load_code   = in_code;
        load_onehot = '0;
        in_ready    = 1'b0;
        unique case (state_q)
            S_PASS: begin
                if (SweepOn && sweep_start && slot_free) begin
                    // Sweep wins over a simultaneous input; code 0 goes out first.
                    state_d     = S_SWEEP;
                    cnt_d       = '0;
                    load        = 1'b1;
                    load_code   = '0;
                    load_onehot = onehot_of('0);
                end else begin
                    in_ready    = slot_free;
                    load        = in_valid && slot_free;
                    load_code   = in_code;
                    load_onehot = in_en ? onehot_of(in_code) : '0;
                end
            end
            S_SWEEP: begin
                if (out_valid && out_ready) begin
                    if (cnt_q == LastCode) begin
                        state_d = S_PASS;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d       = cnt_nxt;
                        load        = 1'b1;
                        load_code   = cnt_nxt;
                        load_onehot = onehot_of(cnt_nxt);
                    end
                end
            end
            default: state_d = S_PASS;
        endcase
    end

    // FSM state, sweep counter and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_PASS;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign sweep_busy = SweepOn && (state_q == S_SWEEP);
    assign sweep_done = done_q;

    hs_reg_slice #(
        .W(IN_W + OUT_W)
    ) u_out_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (load),
        .in_ready (slot_free),
        .in_data  ({load_code, load_onehot}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data ({out_code, out_onehot})
    );

endmodule

// File: tb/tb_hex_onehot_decoder_seq.sv
// Self-checking bench: constant vector table, hand-written corner sequences and
// randomized traffic against a queue-based behavioural model.
module tb_hex_onehot_decoder_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        in_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_onehot;
    logic [3:0]  out_code;
    logic        sweep_start;
    logic        sweep_busy;
    logic        sweep_done;

    int tests = 0;
    int fails = 0;

    // Behavioural model: current output word plus a queue of sweep codes still to emit.
    logic        m_valid;
    logic [15:0] m_onehot;
    logic [3:0]  m_code;
    logic        m_sweep;
    logic        m_done;
    int          m_q[$];

    typedef struct {
        logic [3:0]  code;
        logic        en;
        logic [15:0] exp_oh;
    } vec_t;
    vec_t vecs[17];

    hex_onehot_decoder_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .sweep_start(sweep_start),
        .sweep_busy (sweep_busy),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int enc(input logic [15:0] oh);
        int idx = -1;
        for (int i = 0; i < 16; i++) if (oh[i]) idx = i;
        return idx;
    endfunction

    // One clock: drive inputs, check in_ready, advance model, check registered outputs.
    task automatic tick(input logic v, input logic [3:0] c, input logic e, input logic r,
                        input logic s);
        logic sf;
        int   code;
        in_valid    = v;
        in_code     = c;
        in_en       = e;
        out_ready   = r;
        sweep_start = s;
        #1;
        sf = !m_valid || r;
        chk("in_ready", 32'(in_ready), 32'(!m_sweep && sf && !s));
        if (!rst_n) begin
            m_valid  = 1'b0;
            m_onehot = '0;
            m_code   = '0;
            m_sweep  = 1'b0;
            m_done   = 1'b0;
            m_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_sweep) begin
                if (m_valid && r) begin
                    if (m_q.size() > 0) begin
                        code     = m_q.pop_front();
                        m_code   = 4'(code);
                        m_onehot = 16'd1 << code;
                    end else begin
                        m_valid = 1'b0;
                        m_sweep = 1'b0;
                        m_done  = 1'b1;
                    end
                end
            end else if (s && sf) begin
                m_sweep  = 1'b1;
                m_valid  = 1'b1;
                m_code   = 4'd0;
                m_onehot = 16'd1;
                m_q.delete();
                for (int i = 1; i < 16; i++) m_q.push_back(i);
            end else if (v && sf) begin
                m_valid  = 1'b1;
                m_code   = c;
                m_onehot = e ? (16'd1 << c) : 16'd0;
            end else if (r) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_onehot", 32'(out_onehot), 32'(m_onehot));
        chk("out_code", 32'(out_code), 32'(m_code));
        chk("sweep_busy", 32'(sweep_busy), 32'(m_sweep));
        chk("sweep_done", 32'(sweep_done), 32'(m_done));
        chk("popcount_le1", 32'($countones(out_onehot) <= 1), 32'd1);
        if (out_valid && out_onehot != 16'd0)
            chk("loopback", 32'(enc(out_onehot)), 32'(out_code));
    endtask

    // Runs a started sweep to completion; counts words and checks each against its index.
    task automatic drain_sweep(input int restart_at, output int words, output bit done_seen);
        words     = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (sweep_done) begin
                done_seen = 1'b1;
                break;
            end
            if (out_valid) begin
                chk("sweep_word", 32'(out_onehot), 32'd1 << words);
                words++;
            end
            tick(1'b1, 4'(k), 1'b1, 1'b1, k == restart_at);
        end
    endtask

    initial begin
        int  words;
        bit  done_seen;
        bit  hit7;

        vecs[0]  = '{4'd0,  1'b1, 16'h0001};
        vecs[1]  = '{4'd1,  1'b1, 16'h0002};
        vecs[2]  = '{4'd2,  1'b1, 16'h0004};
        vecs[3]  = '{4'd3,  1'b1, 16'h0008};
        vecs[4]  = '{4'd4,  1'b1, 16'h0010};
        vecs[5]  = '{4'd5,  1'b1, 16'h0020};
        vecs[6]  = '{4'd6,  1'b1, 16'h0040};
        vecs[7]  = '{4'd7,  1'b1, 16'h0080};
        vecs[8]  = '{4'd8,  1'b1, 16'h0100};
        vecs[9]  = '{4'd9,  1'b1, 16'h0200};
        vecs[10] = '{4'd10, 1'b1, 16'h0400};
        vecs[11] = '{4'd11, 1'b1, 16'h0800};
        vecs[12] = '{4'd12, 1'b1, 16'h1000};
        vecs[13] = '{4'd13, 1'b1, 16'h2000};
        vecs[14] = '{4'd14, 1'b1, 16'h4000};
        vecs[15] = '{4'd15, 1'b1, 16'h8000};
        vecs[16] = '{4'd9,  1'b0, 16'h0000};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_code     = '0;
        in_en       = 1'b0;
        out_ready   = 1'b0;
        sweep_start = 1'b0;
        m_valid     = 1'b0;
        m_onehot    = '0;
        m_code      = '0;
        m_sweep     = 1'b0;
        m_done      = 1'b0;
        @(posedge clk);
        #1;

        // Reset state.
        tick(1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_onehot", 32'(out_onehot), 32'd0);
        chk("rst_code", 32'(out_code), 32'd0);
        rst_n = 1'b1;

        // Back-to-back table: every word appears the cycle after it is accepted.
        for (int i = 0; i < 17; i++) begin
            tick(1'b1, vecs[i].code, vecs[i].en, 1'b1, 1'b0);
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_onehot", 32'(out_onehot), 32'(vecs[i].exp_oh));
            chk("tbl_code", 32'(out_code), 32'(vecs[i].code));
        end
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Backpressure: code 3 held for 4 cycles, then 10 accepted as 3 retires.
        tick(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 4'd10, 1'b1, 1'b0, 1'b0);
            chk("bp_hold", 32'(out_onehot), 32'h0008);
        end
        tick(1'b1, 4'd10, 1'b1, 1'b1, 1'b0);
        chk("bp_next", 32'(out_onehot), 32'h0400);
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Plain sweep, then back-to-back input right after the done pulse.
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        drain_sweep(-1, words, done_seen);
        chk("sweep_words", 32'(words), 32'd16);
        chk("sweep_done_seen", 32'(done_seen), 32'd1);
        chk("sweep_busy_end", 32'(sweep_busy), 32'd0);
        tick(1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
        chk("post_sweep", 32'(out_onehot), 32'h0004);

        // Sweep wins over simultaneous input; a restart mid-sweep is ignored.
        tick(1'b1, 4'd6, 1'b1, 1'b1, 1'b1);
        chk("sweep_wins", 32'(out_code), 32'd0);
        drain_sweep(5, words, done_seen);
        chk("sweep2_words", 32'(words), 32'd16);
        chk("sweep2_done_seen", 32'(done_seen), 32'd1);
        for (int i = 0; i < 3; i++) tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Reset after code 7 of a sweep aborts it silently.
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        hit7 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid && out_code == 4'd7) begin
                hit7 = 1'b1;
                break;
            end
            tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        end
        chk("reach_code7", 32'(hit7), 32'd1);
        rst_n = 1'b0;
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_onehot", 32'(out_onehot), 32'd0);
        chk("abort_busy", 32'(sweep_busy), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
            chk("abort_no_done", 32'(sweep_done), 32'd0);
        end
        tick(1'b1, 4'd12, 1'b1, 1'b1, 1'b0);
        chk("abort_next", 32'(out_onehot), 32'h1000);

        // Randomized traffic, including backpressure during sweeps.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 4) != 0, 4'($urandom), 1'($urandom), ($urandom % 3) != 0,
                 ($urandom % 25) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
